// File: rtl/ats_timer_bank.sv
// Multi-counter / alarm timer bank with a single-command req/ready port.
// Counters advance at 1x, 2x or 4x from one reference clock using enables
// derived from a free-running 2-bit prescaler. Alarms compare against the
// value a bound counter increments to and emit a fixed-length pulse.
module ats_timer_bank #(
    parameter int unsigned NUM_CLOCKS = 16,
    parameter int unsigned NUM_ALARMS = 24,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned IDX_W      =
        ((NUM_CLOCKS > NUM_ALARMS ? NUM_CLOCKS : NUM_ALARMS) > 1) ?
        $clog2(NUM_CLOCKS > NUM_ALARMS ? NUM_CLOCKS : NUM_ALARMS) : 1,
    parameter int unsigned CSEL_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [2:0]            cmd_op,
    input  logic [IDX_W-1:0]      cmd_idx,
    input  logic [CSEL_W-1:0]     cmd_clk,
    input  logic [1:0]            cmd_mode,
    input  logic [CNT_W-1:0]      cmd_val,
    output logic                  ready,
    output logic                  resp_valid,
    output logic [1:0]            stat,
    output logic [CNT_W-1:0]      rdata,
    output logic [NUM_ALARMS-1:0] alarm_out
);

    localparam int unsigned PW = $clog2(PULSE_CYC + 1);

    localparam logic [2:0] OpNop    = 3'd0;
    localparam logic [2:0] OpClkSet = 3'd1;
    localparam logic [2:0] OpClkRd  = 3'd2;
    localparam logic [2:0] OpAlmSet = 3'd3;
    localparam logic [2:0] OpAlmClr = 3'd4;

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        p_q;
    logic [CNT_W-1:0]  count_q  [NUM_CLOCKS];
    logic [CNT_W-1:0]  count_d  [NUM_CLOCKS];
    logic [1:0]        rate_q   [NUM_CLOCKS];
    logic [1:0]        rate_d   [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] inc;

    logic [NUM_ALARMS-1:0] en_q, en_d, loop_q, loop_d, cd_q, cd_d;
    logic [CSEL_W-1:0] bind_q   [NUM_ALARMS];
    logic [CSEL_W-1:0] bind_d   [NUM_ALARMS];
    logic [CNT_W-1:0]  target_q [NUM_ALARMS];
    logic [CNT_W-1:0]  target_d [NUM_ALARMS];
    logic [CNT_W-1:0]  delta_q  [NUM_ALARMS];
    logic [CNT_W-1:0]  delta_d  [NUM_ALARMS];
    logic [PW-1:0]     pulse_q  [NUM_ALARMS];
    logic [PW-1:0]     pulse_d  [NUM_ALARMS];

    logic [1:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  rdata_q, rdata_d;

    logic              accept, clk_idx_ok, alm_idx_ok, csel_ok;
    logic              do_clk_set, do_alm_set, do_alm_clr;
    logic [CNT_W-1:0]  sel_count, bsel_count;
    logic [1:0]        bsel_rate;

    function automatic logic rate_tick(input logic [1:0] r, input logic [1:0] p);
        case (r)
            2'b00:   return 1'b0;
            2'b01:   return p == 2'd3;
            2'b10:   return p[0];
            default: return 1'b1;
        endcase
    endfunction

    // Command decode, index checks and lookups of the addressed/bound counter.
    always_comb begin
        accept     = (state_q == StIdle) && req;
        clk_idx_ok = 32'(cmd_idx) < NUM_CLOCKS;
        alm_idx_ok = 32'(cmd_idx) < NUM_ALARMS;
        csel_ok    = 32'(cmd_clk) < NUM_CLOCKS;
        do_clk_set = accept && (cmd_op == OpClkSet) && clk_idx_ok;
        do_alm_set = accept && (cmd_op == OpAlmSet) && alm_idx_ok && csel_ok;
        do_alm_clr = accept && (cmd_op == OpAlmClr) && alm_idx_ok;
        sel_count  = '0;
        bsel_count = '0;
        bsel_rate  = '0;
        for (int j = 0; j < NUM_CLOCKS; j++) begin
            if (32'(j) == 32'(cmd_idx)) sel_count = count_q[j];
            if (32'(j) == 32'(cmd_clk)) begin
                bsel_count = count_q[j];
                bsel_rate  = rate_q[j];
            end
        end
    end

    // Response status and read data for the command accepted this cycle.
    always_comb begin
        stat_d  = 2'b00;
        rdata_d = '0;
        case (cmd_op)
            OpNop:    stat_d = 2'b00;
            OpClkSet: if (!clk_idx_ok) stat_d = 2'b01;
            OpClkRd: begin
                if (!clk_idx_ok) stat_d = 2'b01;
                else             rdata_d = sel_count;
            end
            OpAlmSet: begin
                if (!alm_idx_ok)             stat_d = 2'b01;
                else if (!csel_ok)           stat_d = 2'b10;
                else if (bsel_rate == 2'b00) stat_d = 2'b11;
            end
            OpAlmClr: if (!alm_idx_ok) stat_d = 2'b01;
            default:  stat_d = 2'b10;
        endcase
    end

    // Handshake FSM: one accepted command, then one response cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req) state_d = StResp;
            StResp: state_d = StIdle;
        endcase
    end

    // Counter next state; a CLK_SET overrides that counter's tick.
    always_comb begin
        for (int j = 0; j < NUM_CLOCKS; j++) begin
            logic set_j;
            set_j      = do_clk_set && (32'(j) == 32'(cmd_idx));
            inc[j]     = rate_tick(rate_q[j], p_q) && !set_j;
            count_d[j] = set_j ? cmd_val : (inc[j] ? count_q[j] + CNT_W'(1) : count_q[j]);
            rate_d[j]  = set_j ? cmd_mode : rate_q[j];
        end
    end

    // Alarm next state. A same-cycle ALM_SET/ALM_CLR replaces the old
    // configuration before the fire check, so stale fires are discarded.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            logic              sel_i, e_en, e_loop, e_cd, b_inc, fire;
            logic [CSEL_W-1:0] e_bind;
            logic [CNT_W-1:0]  e_tgt, e_dlt, b_cnt;
            sel_i  = 32'(i) == 32'(cmd_idx);
            e_en   = en_q[i];
            e_loop = loop_q[i];
            e_cd   = cd_q[i];
            e_bind = bind_q[i];
            e_tgt  = target_q[i];
            e_dlt  = delta_q[i];
            pulse_d[i] = (pulse_q[i] != '0) ? pulse_q[i] - PW'(1) : '0;
            if (do_alm_set && sel_i) begin
                e_en       = 1'b1;
                e_loop     = cmd_mode[0];
                e_cd       = cmd_mode[1];
                e_bind     = cmd_clk;
                e_tgt      = cmd_mode[1] ? bsel_count + cmd_val : cmd_val;
                e_dlt      = cmd_val;
                pulse_d[i] = '0;
            end
            if (do_alm_clr && sel_i) begin
                e_en       = 1'b0;
                pulse_d[i] = '0;
            end
            b_inc = 1'b0;
            b_cnt = '0;
            for (int j = 0; j < NUM_CLOCKS; j++) begin
                if (32'(j) == 32'(e_bind)) begin
                    b_inc = inc[j];
                    b_cnt = count_q[j];
                end
            end
            fire        = e_en && b_inc && ((b_cnt + CNT_W'(1)) == e_tgt);
            en_d[i]     = e_en;
            loop_d[i]   = e_loop;
            cd_d[i]     = e_cd;
            bind_d[i]   = e_bind;
            target_d[i] = e_tgt;
            delta_d[i]  = e_dlt;
            if (fire) begin
                pulse_d[i] = PW'(PULSE_CYC);
                if (!e_loop)   en_d[i]     = 1'b0;
                else if (e_cd) target_d[i] = e_tgt + e_dlt;
            end
        end
    end

    // State registers; reset discards any in-flight command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            p_q     <= '0;
            stat_q  <= '0;
            rdata_q <= '0;
            en_q    <= '0;
            loop_q  <= '0;
            cd_q    <= '0;
            for (int j = 0; j < NUM_CLOCKS; j++) begin
                count_q[j] <= '0;
                rate_q[j]  <= '0;
            end
            for (int i = 0; i < NUM_ALARMS; i++) begin
                bind_q[i]   <= '0;
                target_q[i] <= '0;
                delta_q[i]  <= '0;
                pulse_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            p_q     <= p_q + 2'd1;
            stat_q  <= accept ? stat_d : 2'b00;
            rdata_q <= accept ? rdata_d : '0;
            en_q    <= en_d;
            loop_q  <= loop_d;
            cd_q    <= cd_d;
            count_q <= count_d;
            rate_q  <= rate_d;
            bind_q  <= bind_d;
            target_q <= target_d;
            delta_q <= delta_d;
            pulse_q <= pulse_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        ready      = state_q == StIdle;
        resp_valid = state_q == StResp;
        stat       = stat_q;
        rdata      = rdata_q;
        for (int i = 0; i < NUM_ALARMS; i++) alarm_out[i] = pulse_q[i] != '0;
    end

endmodule

// File: tb/tb_ats_timer_bank.sv
// Self-checking bench for ats_timer_bank: table of commands with a response
// scoreboard, a small counter reference model, and hand-timed alarm sequences.
module tb_ats_timer_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_idx = '0;
    logic [3:0]  cmd_clk = '0;
    logic [1:0]  cmd_mode = '0;
    logic [15:0] cmd_val = '0;
    logic        ready, resp_valid;
    logic [1:0]  stat;
    logic [15:0] rdata;
    logic [23:0] alarm_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ats_timer_bank dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .cmd_clk    (cmd_clk),
        .cmd_mode   (cmd_mode),
        .cmd_val    (cmd_val),
        .ready      (ready),
        .resp_valid (resp_valid),
        .stat       (stat),
        .rdata      (rdata),
        .alarm_out  (alarm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference counters: prescaler phase, counts and rates.
    logic [15:0] m_cnt  [16];
    logic [1:0]  m_rate [16];
    logic [1:0]  m_p;
    logic        m_set = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_val = '0;
    logic [1:0]  m_mode = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_p <= '0;
            for (int j = 0; j < 16; j++) begin
                m_cnt[j]  <= '0;
                m_rate[j] <= '0;
            end
        end else begin
            m_p <= m_p + 2'd1;
            for (int j = 0; j < 16; j++) begin
                if (m_set && m_idx == j) begin
                    m_cnt[j]  <= m_val;
                    m_rate[j] <= m_mode;
                end else if (m_rate[j] == 2'd3 || (m_rate[j] == 2'd2 && m_p[0]) ||
                             (m_rate[j] == 2'd1 && m_p == 2'd3)) begin
                    m_cnt[j] <= m_cnt[j] + 16'd1;
                end
            end
        end
    end

    typedef struct { logic [1:0] st; logic [15:0] rd; } exp_t;
    exp_t sb[$];

    // Response monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_stat", 32'(stat), 32'(e.st));
                chk("resp_rdata", 32'(rdata), 32'(e.rd));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic issue(input logic [2:0] op, input int idx, input int cl,
                         input logic [1:0] mode, input logic [15:0] val,
                         input logic [1:0] exp_st, output int acc);
        exp_t e;
        int w;
        cmd_op   = op;
        cmd_idx  = 5'(idx);
        cmd_clk  = 4'(cl);
        cmd_mode = mode;
        cmd_val  = val;
        req      = 1'b1;
        w = 0;
        while (!ready && w < 4) begin
            @(negedge clk);
            w++;
        end
        chk("ready_idle", 32'(ready), 32'd1);
        e.st = exp_st;
        e.rd = (op == 3'd2 && exp_st == 2'b00) ? m_cnt[idx] : 16'd0;
        sb.push_back(e);
        m_set  = (op == 3'd1) && (idx < 16);
        m_idx  = idx;
        m_val  = val;
        m_mode = mode;
        acc = cyc + 1;
        @(negedge clk);
        m_set = 1'b0;
        req   = 1'b0;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("ready_resp", 32'(ready), 32'd0);
    endtask

    typedef struct {
        logic [2:0] op; int idx; int cl; logic [1:0] mode; logic [15:0] val; logic [1:0] st;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] op, input int idx, input int cl,
                                input logic [1:0] mode, input logic [15:0] val,
                                input logic [1:0] st);
        vec_t v;
        v.op = op; v.idx = idx; v.cl = cl; v.mode = mode; v.val = val; v.st = st;
        return v;
    endfunction

    initial begin
        int acc;
        int k;
        logic [31:0] expv;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_stat", 32'(stat), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_alarm", 32'(alarm_out), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Rates, error statuses and reads.
        tbl.push_back(mk(3'd1, 0, 0, 2'b11, 16'd0, 2'b00));
        tbl.push_back(mk(3'd1, 1, 0, 2'b10, 16'd0, 2'b00));
        tbl.push_back(mk(3'd1, 2, 0, 2'b01, 16'd0, 2'b00));
        tbl.push_back(mk(3'd0, 0, 0, 2'b00, 16'd0, 2'b00));
        tbl.push_back(mk(3'd6, 0, 0, 2'b00, 16'd0, 2'b10));
        tbl.push_back(mk(3'd7, 3, 0, 2'b01, 16'd9, 2'b10));
        tbl.push_back(mk(3'd3, 24, 0, 2'b00, 16'd5, 2'b01));
        tbl.push_back(mk(3'd1, 16, 0, 2'b11, 16'd77, 2'b01));
        tbl.push_back(mk(3'd2, 20, 0, 2'b00, 16'd0, 2'b01));
        tbl.push_back(mk(3'd3, 2, 9, 2'b00, 16'd3, 2'b11));
        tbl.push_back(mk(3'd4, 2, 0, 2'b00, 16'd0, 2'b00));
        tbl.push_back(mk(3'd4, 30, 0, 2'b00, 16'd0, 2'b01));
        tbl.push_back(mk(3'd2, 0, 0, 2'b00, 16'd0, 2'b00));
        tbl.push_back(mk(3'd2, 1, 0, 2'b00, 16'd0, 2'b00));
        tbl.push_back(mk(3'd2, 2, 0, 2'b00, 16'd0, 2'b00));
        foreach (tbl[n]) issue(tbl[n].op, tbl[n].idx, tbl[n].cl, tbl[n].mode, tbl[n].val,
                               tbl[n].st, acc);
        repeat (16) @(negedge clk);
        for (int j = 0; j < 3; j++) issue(3'd2, j, 0, 2'b00, 16'd0, 2'b00, acc);
        issue(3'd2, 9, 0, 2'b00, 16'd0, 2'b00, acc);
        chk("alarm_quiet", 32'(alarm_out), 32'd0);

        // Countdown one-shot on a 4x counter: fires on the 10th tick.
        issue(3'd1, 3, 0, 2'b11, 16'd100, 2'b00, acc);
        issue(3'd3, 5, 3, 2'b10, 16'd10, 2'b00, acc);
        for (int n = 0; n < 30; n++) begin
            k = cyc - acc;
            expv = (k == 9 || k == 10) ? 32'h20 : 32'h0;
            chk("oneshot_alarm5", 32'(alarm_out), expv);
            @(negedge clk);
        end

        // Loop countdown delta 4 on the 4x counter 0, then clear.
        issue(3'd3, 23, 0, 2'b11, 16'd4, 2'b00, acc);
        for (int n = 0; n < 20; n++) begin
            k = cyc - acc;
            expv = (k >= 3 && (k % 4 == 3 || k % 4 == 0)) ? 32'h800000 : 32'h0;
            chk("loop_alarm23", 32'(alarm_out), expv);
            @(negedge clk);
        end
        issue(3'd4, 23, 0, 2'b00, 16'd0, 2'b00, acc);
        for (int n = 0; n < 9; n++) begin
            chk("cleared_alarm23", 32'(alarm_out), 32'd0);
            @(negedge clk);
        end

        // Wrap: FFFE -> FFFF -> 0 -> 1, absolute target 1 fires once.
        issue(3'd1, 4, 0, 2'b11, 16'hFFFE, 2'b00, acc);
        issue(3'd3, 7, 4, 2'b00, 16'd1, 2'b00, acc);
        for (int n = 0; n < 20; n++) begin
            k = cyc - acc;
            expv = (k == 1 || k == 2) ? 32'h80 : 32'h0;
            chk("wrap_alarm7", 32'(alarm_out), expv);
            @(negedge clk);
        end
        issue(3'd2, 4, 0, 2'b00, 16'd0, 2'b00, acc);
        issue(3'd2, 3, 0, 2'b00, 16'd0, 2'b00, acc);

        // Reset while in RESP with an alarm pulse active.
        issue(3'd3, 23, 0, 2'b11, 16'd4, 2'b00, acc);
        while (cyc - acc < 6) @(negedge clk);
        cmd_op  = 3'd2;
        cmd_idx = 5'd0;
        req     = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_reset_resp", 32'(resp_valid), 32'd1);
        chk("pre_reset_pulse", 32'(alarm_out[23]), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_reset_ready", 32'(ready), 32'd1);
        chk("mid_reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_reset_alarm", 32'(alarm_out), 32'd0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 16; j++) issue(3'd2, j, 0, 2'b00, 16'd0, 2'b00, acc);
        repeat (8) begin
            chk("post_reset_alarm", 32'(alarm_out), 32'd0);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
